i2s_rx: RTL and testbench
=========================

Name: i2s_rx

Overview:
- Receive-side counterpart of the I2S transmit path: deserialises codec ADC data (ac_adc_sdata) into parallel 24-bit left/right samples.
- FPGA is I2S master, so BCLK/LRCLK come from the transmit-side clock generator; this block only observes them.
- All logic runs on the system clock. Delivers complete stereo frames to Main-side logic over a valid/ready handshake, with overrun reporting.

Parameters:
- WIDTH, 24, sample width in bits per channel.
- SYNC_STAGES, 2, synchroniser flops applied identically to io_bclk, io_lrclk and io_sdata (minimum 1).
- CNT_WIDTH, 8, width of the dropped-frame counter.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous reset, active-high
- io_bclk  in  1  I2S bit clock (oversampled)
- io_lrclk  in  1  I2S word select; 0 = left, 1 = right
- io_sdata  in  1  serial data from codec ADC
- io_outL  out  WIDTH  left sample of the last delivered frame
- io_outR  out  WIDTH  right sample of the last delivered frame
- io_valid  out  1  frame available on io_outL/io_outR
- io_ready  in  1  consumer accepts frame when valid && ready
- io_overrun  out  1  one-cycle pulse when a completed frame is dropped
- io_dropped  out  CNT_WIDTH  saturating count of dropped frames

Behaviour:
- Clock/reset: single clock; reset is synchronous and active-high. Reset clears every output to 0 and forces state SYNC.
- Sampling: all three inputs pass through SYNC_STAGES flops, preserving alignment.
  - A BCLK rise is detected when the synchronised bclk = 1 and its previous value = 0.
  - lrclk and sdata are sampled only on detected rises.
  - Requires BCLK high and low phases of at least 2 clocks each.
- Format: standard I2S.
  - MSB is sampled on the second BCLK rise after an LRCLK transition.
  - The rise at which an LRCLK change is first seen carries the LSB slot of the previous word.
- Per-rise shift logic:
  - If bitcnt < WIDTH, store the bit at position WIDTH-1-bitcnt; bitcnt saturates at WIDTH.
  - Bits beyond WIDTH are ignored.
  - Words shorter than WIDTH are MSB-aligned and zero-padded.
- States:
  - SYNC: ignore data. On the first rise where sampled lrclk goes 1->0, clear the shift register and bitcnt, then go to LEFT. The bit at that rise is discarded.
  - LEFT: shift bits in. On a rise where lrclk goes 0->1: apply this rise's bit first, copy the shift register to pendL, clear the shift register and bitcnt, go to RIGHT.
  - RIGHT: shift bits in. On a rise where lrclk goes 1->0: apply this rise's bit, then the frame is complete with R = shift register and L = pendL. Clear the shift register and bitcnt, go to LEFT.
- Delivery at frame completion (same clock edge):
  - If !io_valid, or io_valid && io_ready in that cycle: load io_outL/io_outR and set io_valid = 1.
  - Otherwise keep the old frame, pulse io_overrun for 1 cycle, and increment io_dropped, saturating at all-ones.
- Valid/ready:
  - io_valid clears on the edge where io_valid && io_ready, unless a new frame loads on that same edge; in that case io_valid stays 1 with the new data.
  - io_outL/io_outR are stable while io_valid = 1.
- Latency: io_valid rises on clock edge N+SYNC_STAGES, where N is the first edge that samples raw io_bclk = 1 on the completing rise.
- Reset mid-frame: partial words are discarded; the next frame is captured only after SYNC sees an lrclk falling edge.

Test Plan:
- Reset held 3 cycles -> io_outL = io_outR = 0, io_valid = 0, io_dropped = 0; random bclk/sdata with lrclk stuck low -> io_valid stays 0.
- 32 BCLK per channel, BCLK period 8 clocks, L = 0x123456, R = 0xABCDEF, io_ready = 1 -> one frame delivered with io_outL = 0x123456, io_outR = 0xABCDEF; io_valid high for exactly 1 cycle; latency = SYNC_STAGES edges after the completing rise.
- 16-bit words (16 BCLK per channel), L = 0x8001, R = 0x7FFE -> io_outL = 0x800100, io_outR = 0x7FFE00.
- io_ready = 0 across 3 frames -> first frame held stable; io_overrun pulses twice; io_dropped = 2. Raise io_ready -> io_valid clears next edge.
- Start stream mid-right-channel after reset -> partial frame discarded; first delivered frame is the first full L/R pair.
- Assert reset for 1 cycle mid-LEFT -> outputs zeroed; the next complete frame after the following lrclk falling edge is delivered correctly.

Source files
------------

// File: rtl/i2s_rx.sv
// i2s_rx: I2S receive deserialiser running entirely on the system clock.
// Oversamples the codec's BCLK/LRCLK/SDATA (driven by the transmit-side
// clock generator), assembles standard-I2S left/right words and hands
// complete stereo frames to the consumer over a valid/ready handshake.
//
// Ports:
//   clock       system clock
//   reset       synchronous reset, active-high
//   io_bclk     I2S bit clock (oversampled, >= 2 clocks per phase)
//   io_lrclk    I2S word select, 0 = left, 1 = right
//   io_sdata    serial data from codec ADC
//   io_outL     left sample of the last delivered frame
//   io_outR     right sample of the last delivered frame
//   io_valid    frame available on io_outL/io_outR
//   io_ready    consumer accepts the frame when io_valid && io_ready
//   io_overrun  one-cycle pulse when a completed frame is dropped
//   io_dropped  saturating count of dropped frames
module i2s_rx #(
    parameter int unsigned WIDTH       = 24,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_WIDTH   = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 io_bclk,
    input  logic                 io_lrclk,
    input  logic                 io_sdata,
    output logic [WIDTH-1:0]     io_outL,
    output logic [WIDTH-1:0]     io_outR,
    output logic                 io_valid,
    input  logic                 io_ready,
    output logic                 io_overrun,
    output logic [CNT_WIDTH-1:0] io_dropped
);

    localparam int unsigned BW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_LEFT  = 2'd1,
        ST_RIGHT = 2'd2
    } state_t;

    // Synchroniser chains; identical depth keeps the three inputs aligned.
    logic [SYNC_STAGES-1:0] bclk_sync;
    logic [SYNC_STAGES-1:0] lr_sync;
    logic [SYNC_STAGES-1:0] sd_sync;

    logic bclk_s;
    logic lr_s;
    logic sd_s;
    logic rise_c;

    state_t               state_q,   state_d;
    logic [WIDTH-1:0]     shreg_q,   shreg_d;
    logic [BW-1:0]        bitcnt_q,  bitcnt_d;
    logic [WIDTH-1:0]     pend_l_q,  pend_l_d;
    logic                 lr_prev_q, lr_prev_d;
    logic                 bclk_prev_q;
    logic [WIDTH-1:0]     out_l_q,   out_l_d;
    logic [WIDTH-1:0]     out_r_q,   out_r_d;
    logic                 valid_q,   valid_d;
    logic                 overrun_q, overrun_d;
    logic [CNT_WIDTH-1:0] dropped_q, dropped_d;

    logic [WIDTH-1:0]     shreg_bit;
    logic [BW-1:0]        bitcnt_inc;

    // Input synchronisers
    always_ff @(posedge clock) begin
        if (reset) begin
            bclk_sync <= '0;
            lr_sync   <= '0;
            sd_sync   <= '0;
        end else begin
            for (int i = int'(SYNC_STAGES) - 1; i > 0; i--) begin
                bclk_sync[i] <= bclk_sync[i-1];
                lr_sync[i]   <= lr_sync[i-1];
                sd_sync[i]   <= sd_sync[i-1];
            end
            bclk_sync[0] <= io_bclk;
            lr_sync[0]   <= io_lrclk;
            sd_sync[0]   <= io_sdata;
        end
    end

    assign bclk_s = bclk_sync[SYNC_STAGES-1];
    assign lr_s   = lr_sync[SYNC_STAGES-1];
    assign sd_s   = sd_sync[SYNC_STAGES-1];
    assign rise_c = bclk_s & ~bclk_prev_q;

    // Shift register with the current rise's bit applied (MSB first).
    // Once bitcnt has saturated at WIDTH no position matches, so extra
    // bits fall away and short words stay MSB-aligned over zeros.
    always_comb begin
        shreg_bit = shreg_q;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (bitcnt_q == BW'(WIDTH - 1 - i)) begin
                shreg_bit[i] = sd_s;
            end
        end
    end

    assign bitcnt_inc = (bitcnt_q < BW'(WIDTH)) ? bitcnt_q + BW'(1) : bitcnt_q;

    // State and datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_SYNC;
            shreg_q     <= '0;
            bitcnt_q    <= '0;
            pend_l_q    <= '0;
            lr_prev_q   <= 1'b0;
            bclk_prev_q <= 1'b0;
            out_l_q     <= '0;
            out_r_q     <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            dropped_q   <= '0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bitcnt_q    <= bitcnt_d;
            pend_l_q    <= pend_l_d;
            lr_prev_q   <= lr_prev_d;
            bclk_prev_q <= bclk_s;
            out_l_q     <= out_l_d;
            out_r_q     <= out_r_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
            dropped_q   <= dropped_d;
        end
    end

    // Next-state, word assembly and frame delivery
    always_comb begin
        logic frame_done;

        state_d    = state_q;
        shreg_d    = shreg_q;
        bitcnt_d   = bitcnt_q;
        pend_l_d   = pend_l_q;
        lr_prev_d  = lr_prev_q;
        out_l_d    = out_l_q;
        out_r_d    = out_r_q;
        valid_d    = valid_q & ~io_ready;
        overrun_d  = 1'b0;
        dropped_d  = dropped_q;
        frame_done = 1'b0;

        if (rise_c) begin
            lr_prev_d = lr_s;
            case (state_q)
                ST_SYNC: begin
                    // First left word boundary; this rise's bit belongs to
                    // an unknown earlier word and is dropped.
                    if (lr_prev_q && !lr_s) begin
                        shreg_d  = '0;
                        bitcnt_d = '0;
                        state_d  = ST_LEFT;
                    end
                end
                ST_LEFT: begin
                    if (!lr_prev_q && lr_s) begin
                        // This rise still carries the left LSB slot.
                        pend_l_d = shreg_bit;
                        shreg_d  = '0;
                        bitcnt_d = '0;
                        state_d  = ST_RIGHT;
                    end else begin
                        shreg_d  = shreg_bit;
                        bitcnt_d = bitcnt_inc;
                    end
                end
                ST_RIGHT: begin
                    if (lr_prev_q && !lr_s) begin
                        frame_done = 1'b1;
                        shreg_d    = '0;
                        bitcnt_d   = '0;
                        state_d    = ST_LEFT;
                    end else begin
                        shreg_d  = shreg_bit;
                        bitcnt_d = bitcnt_inc;
                    end
                end
                default: begin
                    state_d = ST_SYNC;
                end
            endcase
        end

        // A frame loads if the output slot is free or is being taken now.
        if (frame_done) begin
            if (!valid_q || io_ready) begin
                out_l_d = pend_l_q;
                out_r_d = shreg_bit;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
                if (dropped_q != {CNT_WIDTH{1'b1}}) begin
                    dropped_d = dropped_q + CNT_WIDTH'(1);
                end
            end
        end
    end

    assign io_outL    = out_l_q;
    assign io_outR    = out_r_q;
    assign io_valid   = valid_q;
    assign io_overrun = overrun_q;
    assign io_dropped = dropped_q;

endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx: directed/random bench for i2s_rx. Streams are built as lists
// of BCLK slots (word-select value + data bit); the emitter delays data by
// one slot as standard I2S requires. Expected samples come from a simple
// truncate/zero-pad rule applied to the words that were sent.
module tb_i2s_rx;

    localparam int unsigned WIDTH = 24;
    localparam int unsigned SYNC  = 2;
    localparam int unsigned CW    = 8;

    logic             clk;
    logic             reset;
    logic             bclk;
    logic             lrclk;
    logic             sdata;
    logic             ready;
    logic [WIDTH-1:0] out_l;
    logic [WIDTH-1:0] out_r;
    logic             valid;
    logic             overrun;
    logic [CW-1:0]    dropped;

    int total = 0;
    int bad   = 0;

    int cyc         = 0;
    int ovr_cnt     = 0;
    int vcyc        = 0;
    int first_valid = -1;
    int unstable    = 0;
    logic        v_prev   = 1'b0;
    logic        hs_prev  = 1'b0;
    logic [47:0] out_prev = '0;

    logic [47:0] got_q[$];
    logic        lr_q[$];
    logic        bit_q[$];
    int          rise_q[$];
    logic [23:0] exp_l[$];
    logic [23:0] exp_r[$];

    i2s_rx #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC), .CNT_WIDTH(CW)) dut (
        .clock      (clk),
        .reset      (reset),
        .io_bclk    (bclk),
        .io_lrclk   (lrclk),
        .io_sdata   (sdata),
        .io_outL    (out_l),
        .io_outR    (out_r),
        .io_valid   (valid),
        .io_ready   (ready),
        .io_overrun (overrun),
        .io_dropped (dropped)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Observer: handshakes, overrun pulses, valid timing, output stability.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (valid && ready) got_q.push_back({out_l, out_r});
        if (overrun) ovr_cnt <= ovr_cnt + 1;
        if (valid) vcyc <= vcyc + 1;
        if (valid && !v_prev) first_valid <= cyc;
        if (v_prev && !hs_prev && valid && ({out_l, out_r} != out_prev))
            unstable <= unstable + 1;
        v_prev   <= valid;
        hs_prev  <= valid && ready;
        out_prev <= {out_l, out_r};
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference rule: keep the top WIDTH bits, zero-pad short words.
    function automatic logic [23:0] exp24(input logic [31:0] w, input int nbits);
        logic [31:0] t;
        if (nbits >= 24) t = w >> (nbits - 24);
        else             t = w << (24 - nbits);
        return t[23:0];
    endfunction

    task automatic clear_stream();
        lr_q.delete(); bit_q.delete(); rise_q.delete();
        exp_l.delete(); exp_r.delete();
    endtask

    task automatic add_word(input logic lr, input logic [31:0] w, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) begin
            lr_q.push_back(lr);
            bit_q.push_back(w[i]);
        end
    endtask

    task automatic add_fill(input logic lr, input int n);
        for (int i = 0; i < n; i++) begin
            lr_q.push_back(lr);
            bit_q.push_back(1'($urandom));
        end
    endtask

    task automatic add_frame(input logic [31:0] wl, input logic [31:0] wr, input int nbits);
        add_word(1'b0, wl, nbits);
        add_word(1'b1, wr, nbits);
        exp_l.push_back(exp24(wl, nbits));
        exp_r.push_back(exp24(wr, nbits));
    endtask

    // One BCLK period per slot: 4 clocks low, 4 clocks high.
    task automatic emit(input int from, input int upto);
        for (int k = from; k < upto; k++) begin
            bclk  = 1'b0;
            lrclk = lr_q[k];
            sdata = (k == 0) ? 1'($urandom) : bit_q[k-1];
            repeat (4) @(negedge clk);
            bclk = 1'b1;
            rise_q.push_back(cyc);
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        reset = 1'b1;
        bclk  = 1'b0;
        repeat (n) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [47:0] g;
        int v0, o0, u0, rs;
        logic [31:0] wl, wr;

        reset = 1'b0; bclk = 1'b0; lrclk = 1'b0; sdata = 1'b0; ready = 1'b1;
        repeat (2) @(negedge clk);

        // Reset state, then random activity with word select stuck low.
        do_reset(3);
        check("rst_outL", 64'(out_l), 64'(0));
        check("rst_outR", 64'(out_r), 64'(0));
        check("rst_valid", 64'(valid), 64'(0));
        check("rst_dropped", 64'(dropped), 64'(0));
        check("rst_overrun", 64'(overrun), 64'(0));
        for (int i = 0; i < 40; i++) begin
            bclk  = 1'($urandom);
            sdata = 1'($urandom);
            lrclk = 1'b0;
            repeat ($urandom_range(2, 5)) @(negedge clk);
        end
        check("lr_low_valid", 64'(valid), 64'(0));
        check("lr_low_frames", 64'(got_q.size()), 64'(0));

        // 32-slot frame with fixed samples and random trailing bits.
        do_reset(1);
        clear_stream();
        add_fill(1'b1, 2);
        add_frame({24'h123456, 8'($urandom)}, {24'hABCDEF, 8'($urandom)}, 32);
        add_fill(1'b0, 4);
        got_q.delete();
        v0 = vcyc;
        emit(0, lr_q.size());
        repeat (4) @(negedge clk);
        check("f32_count", 64'(got_q.size()), 64'(1));
        g = (got_q.size() > 0) ? got_q.pop_front() : '0;
        check("f32_L", 64'(g[47:24]), 64'(exp_l[0]));
        check("f32_R", 64'(g[23:0]), 64'(exp_r[0]));
        check("f32_latency", 64'(first_valid), 64'(rise_q[2 + 64] + 1 + int'(SYNC)));
        check("f32_valid_cycles", 64'(vcyc - v0), 64'(1));
        check("f32_dropped", 64'(dropped), 64'(0));

        // 16-bit words: fixed pair then random words.
        do_reset(1);
        clear_stream();
        add_fill(1'b1, 2);
        add_frame(32'h8001, 32'h7FFE, 16);
        for (int i = 0; i < 2; i++) add_frame(32'($urandom_range(0, 65535)), 32'($urandom_range(0, 65535)), 16);
        add_fill(1'b0, 4);
        got_q.delete();
        emit(0, lr_q.size());
        repeat (4) @(negedge clk);
        check("f16_count", 64'(got_q.size()), 64'(3));
        for (int i = 0; i < 3; i++) begin
            g = (got_q.size() > 0) ? got_q.pop_front() : '0;
            check($sformatf("f16_L%0d", i), 64'(g[47:24]), 64'(exp_l[i]));
            check($sformatf("f16_R%0d", i), 64'(g[23:0]), 64'(exp_r[i]));
        end

        // Backpressure: three frames with ready low.
        ready = 1'b0;
        do_reset(1);
        clear_stream();
        add_fill(1'b1, 2);
        for (int i = 0; i < 3; i++) add_frame($urandom, $urandom, 32);
        add_fill(1'b0, 4);
        got_q.delete();
        o0 = ovr_cnt;
        u0 = unstable;
        emit(0, lr_q.size());
        repeat (4) @(negedge clk);
        check("bp_no_handshake", 64'(got_q.size()), 64'(0));
        check("bp_valid", 64'(valid), 64'(1));
        check("bp_hold_L", 64'(out_l), 64'(exp_l[0]));
        check("bp_hold_R", 64'(out_r), 64'(exp_r[0]));
        check("bp_overruns", 64'(ovr_cnt - o0), 64'(2));
        check("bp_dropped", 64'(dropped), 64'(2));
        check("bp_stable", 64'(unstable - u0), 64'(0));
        ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", 64'(valid), 64'(0));
        check("bp_release_count", 64'(got_q.size()), 64'(1));
        g = (got_q.size() > 0) ? got_q.pop_front() : '0;
        check("bp_release_data", 64'(g), 64'({exp_l[0], exp_r[0]}));

        // Stream joins mid-word: partial left then right are discarded.
        do_reset(1);
        clear_stream();
        add_fill(1'b0, 6);
        add_fill(1'b1, 20);
        for (int i = 0; i < 2; i++) add_frame($urandom, $urandom, 32);
        add_fill(1'b0, 4);
        got_q.delete();
        emit(0, lr_q.size());
        repeat (4) @(negedge clk);
        check("mid_count", 64'(got_q.size()), 64'(2));
        for (int i = 0; i < 2; i++) begin
            g = (got_q.size() > 0) ? got_q.pop_front() : '0;
            check($sformatf("mid_frame%0d", i), 64'(g), 64'({exp_l[i], exp_r[i]}));
        end

        // One-cycle reset in the middle of the second frame's left word.
        do_reset(1);
        clear_stream();
        add_fill(1'b1, 2);
        for (int i = 0; i < 4; i++) add_frame($urandom, $urandom, 32);
        add_fill(1'b0, 4);
        got_q.delete();
        rs = 2 + 64 + 10;
        emit(0, rs);
        check("mr_before_count", 64'(got_q.size()), 64'(1));
        g = (got_q.size() > 0) ? got_q.pop_front() : '0;
        check("mr_before_data", 64'(g), 64'({exp_l[0], exp_r[0]}));
        do_reset(1);
        check("mr_rst_outL", 64'(out_l), 64'(0));
        check("mr_rst_outR", 64'(out_r), 64'(0));
        check("mr_rst_valid", 64'(valid), 64'(0));
        emit(rs, lr_q.size());
        repeat (4) @(negedge clk);
        check("mr_after_count", 64'(got_q.size()), 64'(2));
        for (int i = 2; i < 4; i++) begin
            g = (got_q.size() > 0) ? got_q.pop_front() : '0;
            check($sformatf("mr_after_frame%0d", i), 64'(g), 64'({exp_l[i], exp_r[i]}));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
